// File: rtl/adc_pkg.sv
// Shared constants for the paddle ADC front end: FSM encodings, default timing, output width.
package adc_pkg;

   localparam int unsigned CLK_DIV_DEF       = 25;
   localparam int unsigned CNV_CYCLES_DEF    = 2;
   localparam int unsigned CONV_CYCLES_DEF   = 100;
   localparam int unsigned SAMPLE_PERIOD_DEF = 50000;
   localparam int unsigned NBITS_DEF         = 12;
   localparam int unsigned OUT_W             = 8;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CNV   = 3'd1;
   localparam logic [2:0] S_CONV  = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: idles high, first falls on the cycle after enable, then
// alternates CLK_DIV-cycle halves. Strobes flag the cycle before each level change.
module adc_sclk_gen
   import adc_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_sclk,
   output logic o_rise_c,
   output logic o_fall_c
);

   localparam int unsigned   CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_sclk;
   logic          r_run;
   logic          w_wrap;

   assign w_wrap = r_run && (r_cnt == CNT_MAX);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || !i_en) begin
         r_cnt  <= '0;
         r_sclk <= 1'b1;
         r_run  <= 1'b0;
      end else if (!r_run) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
         r_run  <= 1'b1;
      end else if (w_wrap) begin
         r_cnt  <= '0;
         r_sclk <= ~r_sclk;
      end else begin
         r_cnt  <= r_cnt + CW'(1);
      end
   end

   assign o_sclk   = r_sclk;
   assign o_rise_c = w_wrap & ~r_sclk;
   assign o_fall_c = w_wrap & r_sclk;

endmodule

// File: rtl/adc_paddle_reader.sv
// Dual-channel serial ADC reader: periodic CNVST/CS_N/SCLK frames, MSB-first capture,
// top byte of each channel latched with a one-cycle valid strobe.
module adc_paddle_reader
   import adc_pkg::*;
#(
   parameter int unsigned CLK_DIV       = CLK_DIV_DEF,
   parameter int unsigned CNV_CYCLES    = CNV_CYCLES_DEF,
   parameter int unsigned CONV_CYCLES   = CONV_CYCLES_DEF,
   parameter int unsigned SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
   parameter int unsigned NBITS         = NBITS_DEF
) (
   input  logic             clock_50MHz,
   input  logic             RESET_n,
   input  logic [1:0]       ADC_OUT,
   output logic             ADC_CNVST,
   output logic             ADC_CS_N,
   output logic             ADC_SCLK,
   output logic             ADC_REFSEL,
   output logic             ADC_SD,
   output logic             ADC_UB,
   output logic             ADC_SEL,
   output logic             BUSY,
   output logic [OUT_W-1:0] DATA_AD0,
   output logic [OUT_W-1:0] DATA_AD1,
   output logic             DATA_VALID
);

   localparam int unsigned   PH_MAX     = (CONV_CYCLES > CNV_CYCLES) ? CONV_CYCLES : CNV_CYCLES;
   localparam int unsigned   PW         = $clog2(PH_MAX + 1);
   localparam int unsigned   TW         = $clog2(SAMPLE_PERIOD + 1);
   localparam int unsigned   BW         = $clog2(NBITS + 1);
   localparam logic [PW-1:0] CNV_LAST   = PW'(CNV_CYCLES - 1);
   localparam logic [PW-1:0] CONV_LAST  = PW'(CONV_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
   localparam logic [BW-1:0] BIT_ALL    = BW'(NBITS);

   logic [2:0]       r_state;
   logic [2:0]       w_nxt;
   logic             r_start;
   logic [PW-1:0]    r_ph;
   logic [TW-1:0]    r_timer;
   logic [BW-1:0]    r_bit;
   logic [NBITS-1:0] r_sh0;
   logic [NBITS-1:0] r_sh1;
   logic             w_sclk_en;
   logic             w_sclk;
   logic             w_rise;
   logic             w_fall;

   assign ADC_REFSEL = 1'b0;
   assign ADC_SD     = 1'b0;
   assign ADC_UB     = 1'b0;
   assign ADC_SEL    = 1'b0;
   assign ADC_SCLK   = w_sclk;
   assign w_sclk_en  = (w_nxt == S_SHIFT);

   adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .i_clk    (clock_50MHz),
      .i_rst_n  (RESET_n),
      .i_en     (w_sclk_en),
      .o_sclk   (w_sclk),
      .o_rise_c (w_rise),
      .o_fall_c (w_fall)
   );

   // Frame sequencing; a frame only ends after the last high half-period of SCLK.
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:  if (r_start || (r_timer >= TIMER_LAST)) w_nxt = S_CNV;
         S_CNV:   if (r_ph == CNV_LAST)                   w_nxt = S_CONV;
         S_CONV:  if (r_ph == CONV_LAST)                  w_nxt = S_SHIFT;
         S_SHIFT: if (w_fall && (r_bit == BIT_ALL))       w_nxt = S_DONE;
         S_DONE:  w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_50MHz) begin
      if (!RESET_n) begin
         r_state    <= S_IDLE;
         r_start    <= 1'b1;
         r_ph       <= '0;
         r_timer    <= '0;
         r_bit      <= '0;
         r_sh0      <= '0;
         r_sh1      <= '0;
         ADC_CNVST  <= 1'b1;
         ADC_CS_N   <= 1'b1;
         BUSY       <= 1'b0;
         DATA_VALID <= 1'b0;
         DATA_AD0   <= '0;
         DATA_AD1   <= '0;
      end else begin
         r_state <= w_nxt;
         if (r_state == S_IDLE && w_nxt == S_CNV) r_start <= 1'b0;

         if (w_nxt != r_state)                          r_ph <= '0;
         else if (r_state == S_CNV || r_state == S_CONV) r_ph <= r_ph + PW'(1);

         // Timer restarts with each frame and saturates so overlong frames still trigger.
         if (r_state == S_IDLE && w_nxt == S_CNV) r_timer <= '0;
         else if (r_timer != '1)                  r_timer <= r_timer + TW'(1);

         if (r_state == S_IDLE) begin
            r_bit <= '0;
         end else if (r_state == S_SHIFT && w_rise) begin
            r_bit <= r_bit + BW'(1);
            r_sh0 <= {r_sh0[NBITS-2:0], ADC_OUT[0]};
            r_sh1 <= {r_sh1[NBITS-2:0], ADC_OUT[1]};
         end

         // Outputs are decoded from the next state so they line up with the state register.
         ADC_CNVST  <= (w_nxt != S_CNV);
         ADC_CS_N   <= (w_nxt != S_SHIFT);
         BUSY       <= (w_nxt != S_IDLE);
         DATA_VALID <= (w_nxt == S_DONE);
         if (w_nxt == S_DONE) begin
            DATA_AD0 <= r_sh0[NBITS-1 -: OUT_W];
            DATA_AD1 <= r_sh1[NBITS-1 -: OUT_W];
         end
      end
   end

endmodule

// File: tb/tb_adc_paddle_reader.sv
// Directed bench for adc_paddle_reader: unit A (1000-cycle period) and unit B (500-cycle
// period, frames longer than the period) each served by a serial ADC model.
module tb_adc_paddle_reader;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic [1:0] rst_n;
   logic [1:0] adc [2];
   logic [1:0] cnvst, cs_n, sclk, busy, valid;
   logic [3:0] cfg_a, cfg_b;
   logic [7:0] d0 [2];
   logic [7:0] d1 [2];

   adc_paddle_reader #(.SAMPLE_PERIOD(1000)) u_dut_a (
      .clock_50MHz(clk), .RESET_n(rst_n[0]), .ADC_OUT(adc[0]),
      .ADC_CNVST(cnvst[0]), .ADC_CS_N(cs_n[0]), .ADC_SCLK(sclk[0]),
      .ADC_REFSEL(cfg_a[0]), .ADC_SD(cfg_a[1]), .ADC_UB(cfg_a[2]), .ADC_SEL(cfg_a[3]),
      .BUSY(busy[0]), .DATA_AD0(d0[0]), .DATA_AD1(d1[0]), .DATA_VALID(valid[0])
   );

   adc_paddle_reader #(.SAMPLE_PERIOD(500)) u_dut_b (
      .clock_50MHz(clk), .RESET_n(rst_n[1]), .ADC_OUT(adc[1]),
      .ADC_CNVST(cnvst[1]), .ADC_CS_N(cs_n[1]), .ADC_SCLK(sclk[1]),
      .ADC_REFSEL(cfg_b[0]), .ADC_SD(cfg_b[1]), .ADC_UB(cfg_b[2]), .ADC_SEL(cfg_b[3]),
      .BUSY(busy[1]), .DATA_AD0(d0[1]), .DATA_AD1(d1[1]), .DATA_VALID(valid[1])
   );

   logic [11:0] w0 [2];
   logic [11:0] w1 [2];
   logic [1:0]  p_sclk  = 2'b11;
   logic [1:0]  p_cnvst = 2'b11;
   logic [1:0]  p_cs    = 2'b11;
   int rc [2];
   int rises [2];
   int win_bad [2];
   int n_win [2];
   int viol [2];
   int cnv_t [2][64];
   int n_cnv [2];
   int val_t [2][64];
   int n_val [2];
   int lo_run [2];
   int last_lo [2];
   int cyc;
   int n_tests, n_fail;

   always @(posedge clk) cyc <= cyc + 1;

   // Protocol monitor plus ADC model: a new bit is presented after each SCLK rise, MSB first.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (p_cnvst[d] && !cnvst[d]) begin
            if (n_cnv[d] < 64) cnv_t[d][n_cnv[d]] = cyc;
            n_cnv[d]++;
         end
         if (valid[d]) begin
            if (n_val[d] < 64) val_t[d][n_val[d]] = cyc;
            n_val[d]++;
         end
         if (cs_n[d] && !sclk[d]) viol[d]++;
         if (!cnvst[d] && !cs_n[d]) viol[d]++;
         if (!cs_n[d] && sclk[d] && !p_sclk[d]) rises[d]++;
         if (cs_n[d] && !p_cs[d]) begin
            n_win[d]++;
            if (rises[d] != 12) win_bad[d]++;
            rises[d] = 0;
         end
         if (!busy[d]) lo_run[d]++;
         else if (lo_run[d] != 0) begin
            last_lo[d] = lo_run[d];
            lo_run[d]  = 0;
         end
         if (cs_n[d]) rc[d] = 0;
         else if (sclk[d] && !p_sclk[d]) rc[d]++;
         adc[d] = (rc[d] < 12) ? {w1[d][11 - rc[d]], w0[d][11 - rc[d]]} : 2'b00;
         p_sclk[d]  = sclk[d];
         p_cnvst[d] = cnvst[d];
         p_cs[d]    = cs_n[d];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_to(input int t);
      while (cyc < t) step();
   endtask

   int t0, t1, tb, vb, nv;
   int first_cs, first_sl, first_val, cnv_lo, busy_n;
   logic cnv0, busy_end, ok;
   logic [7:0] v_d0, v_d1;
   logic [7:0] exp_walk [9];

   initial begin
      exp_walk = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
      rst_n = 2'b00;
      w0[0] = 12'hA5F; w1[0] = 12'h3C0;
      w0[1] = 12'h123; w1[1] = 12'hFED;
      repeat (5) step();

      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_ctl%0d", d), 32'({cnvst[d], cs_n[d], sclk[d], busy[d], valid[d]}), 32'h1C);
         chk($sformatf("rst_d0_%0d", d), 32'(d0[d]), 32'h0);
         chk($sformatf("rst_d1_%0d", d), 32'(d1[d]), 32'h0);
      end
      chk("rst_cfg", 32'({cfg_a, cfg_b}), 32'h0);

      // First frame after reset release, default timing
      rst_n[0] = 1'b1;
      t0 = cyc + 1;
      first_cs = -1; first_sl = -1; first_val = -1; cnv_lo = 0; busy_n = 0;
      cnv0 = 1'b1; busy_end = 1'b1; v_d0 = '0; v_d1 = '0;
      for (int c = 0; c <= 703; c++) begin
         step();
         if (c == 0) cnv0 = cnvst[0];
         if (!cnvst[0]) cnv_lo++;
         if (!cs_n[0] && first_cs < 0) first_cs = c;
         if (!sclk[0] && first_sl < 0) first_sl = c;
         if (valid[0] && first_val < 0) begin
            first_val = c; v_d0 = d0[0]; v_d1 = d1[0];
         end
         if (busy[0]) busy_n++;
         if (c == 703) busy_end = busy[0];
      end
      chk("f1_cnvst_c0", 32'(cnv0), 32'h0);
      chk("f1_cnvst_len", 32'(cnv_lo), 32'd2);
      chk("f1_cs_fall", 32'(first_cs), 32'd102);
      chk("f1_sclk_fall", 32'(first_sl), 32'd102);
      chk("f1_valid_cyc", 32'(first_val), 32'd702);
      chk("f1_d0", 32'(v_d0), 32'hA5);
      chk("f1_d1", 32'(v_d1), 32'h3C);
      chk("f1_busy_len", 32'(busy_n), 32'd703);
      chk("f1_busy_end", 32'(busy_end), 32'h0);
      chk("run_cfg", 32'(cfg_a), 32'h0);

      // Steady run, three frames at the sample period
      w0[0] = 12'hFFF; w1[0] = 12'h000;
      vb = n_val[0];
      step_to(t0 + 3705);
      chk("st_ncnv", 32'(n_cnv[0]), 32'd4);
      chk("st_cnv0", 32'(cnv_t[0][0] - t0), 32'd0);
      chk("st_cnv1", 32'(cnv_t[0][1] - t0), 32'd1000);
      chk("st_cnv2", 32'(cnv_t[0][2] - t0), 32'd2000);
      chk("st_cnv3", 32'(cnv_t[0][3] - t0), 32'd3000);
      chk("st_nvalid", 32'(n_val[0] - vb), 32'd3);
      chk("st_d0", 32'(d0[0]), 32'hFF);
      chk("st_d1", 32'(d1[0]), 32'h00);
      chk("st_viol", 32'(viol[0]), 32'd0);
      chk("st_win_bad", 32'(win_bad[0]), 32'd0);
      chk("st_nwin", 32'(n_win[0]), 32'd4);

      // One-cycle reset in the middle of the seventh bit
      w0[0] = 12'hA5F; w1[0] = 12'h3C0;
      step_to(t0 + 4410);
      chk("mr_pre_cs", 32'(cs_n[0]), 32'h0);
      nv = n_val[0];
      rst_n[0] = 1'b0;
      step();
      chk("mr_ctl", 32'({cnvst[0], cs_n[0], sclk[0], busy[0], valid[0]}), 32'h1C);
      chk("mr_d0", 32'(d0[0]), 32'h0);
      chk("mr_d1", 32'(d1[0]), 32'h0);
      rst_n[0] = 1'b1;
      t1 = cyc + 1;
      step();
      chk("mr_restart", 32'(cnvst[0]), 32'h0);
      step_to(t1 + 701);
      chk("mr_no_valid", 32'(n_val[0] - nv), 32'd0);
      step();
      chk("mr_valid", 32'(valid[0]), 32'h1);
      chk("mr_new_d0", 32'(d0[0]), 32'hA5);
      chk("mr_new_d1", 32'(d1[0]), 32'h3C);

      // Channel isolation: walking one on ch0, fixed pattern on ch1
      for (int k = 0; k < 9; k++) begin
         w0[0] = 12'h800 >> k;
         w1[0] = 12'h555;
         ok = 1'b0;
         for (int i = 0; i < 1100 && !ok; i++) begin
            step();
            if (valid[0]) ok = 1'b1;
         end
         chk($sformatf("walk%0d_seen", k), 32'(ok), 32'h1);
         chk($sformatf("walk%0d_d0", k), 32'(d0[0]), 32'(exp_walk[k]));
         chk($sformatf("walk%0d_d1", k), 32'(d1[0]), 32'h55);
      end

      // Unit B: period shorter than a frame, frames run back to back
      rst_n[1] = 1'b1;
      tb = cyc + 1;
      step_to(tb + 1412);
      chk("bb_ncnv", 32'(n_cnv[1]), 32'd3);
      chk("bb_cnv0", 32'(cnv_t[1][0] - tb), 32'd0);
      chk("bb_cnv1", 32'(cnv_t[1][1] - tb), 32'd704);
      chk("bb_cnv2", 32'(cnv_t[1][2] - tb), 32'd1408);
      chk("bb_val0", 32'(val_t[1][0] - tb), 32'd702);
      chk("bb_val1", 32'(val_t[1][1] - tb), 32'd1406);
      chk("bb_gap", 32'(last_lo[1]), 32'd1);
      chk("bb_d0", 32'(d0[1]), 32'h12);
      chk("bb_d1", 32'(d1[1]), 32'hFE);
      chk("bb_viol", 32'(viol[1]), 32'd0);
      chk("bb_win_bad", 32'(win_bad[1]), 32'd0);
      chk("bb_nwin", 32'(n_win[1]), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
